// File: rtl/sym_slicer_4ask_if.sv
// Sample/decision bundle between the matched filter, the 4-ASK slicer and
// its downstream consumers.
interface sym_slicer_4ask_if #(
  parameter int WIDTH = 18
);
  logic                    sam_clk_en;
  logic [1:0]              phase;
  logic                    freeze;
  logic signed [WIDTH-1:0] x_in;
  logic                    sym_valid;
  logic [1:0]              dec;
  logic signed [WIDTH-1:0] err;
  logic [WIDTH-1:0]        ref_level;
  logic                    ref_valid;

  modport master (
    output sam_clk_en, phase, freeze, x_in,
    input  sym_valid, dec, err, ref_level, ref_valid
  );

  modport slave (
    input  sam_clk_en, phase, freeze, x_in,
    output sym_valid, dec, err, ref_level, ref_valid
  );
endinterface

// File: rtl/sym_slicer_4ask.sv
// Picks one 1s17 sample per symbol, slices it to 4-ASK against a running
// mean of |x| and reports the signed slicer error.
module sym_slicer_4ask #(
  parameter int               WIDTH    = 18,
  parameter int               ACC_LOG2 = 7,
  parameter logic [WIDTH-1:0] INIT_REF = WIDTH'(32768)
) (
  input logic               sys_clk,
  input logic               reset_n,
  sym_slicer_4ask_if.slave  bus
);
  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + ACC_LOG2;
  localparam logic signed [XW-1:0]  ERR_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0]  ERR_MIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]      ABS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] X_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]              samp_cnt;
  logic                    capture;
  logic                    proc;
  logic signed [WIDTH-1:0] x_sym;

  logic [AW-1:0]           acc;
  logic [ACC_LOG2-1:0]     sym_cnt;
  logic [WIDTH-1:0]        ref_level_q;
  logic                    ref_valid_q;
  logic                    sym_valid_q;
  logic [1:0]              dec_q;
  logic signed [WIDTH-1:0] err_q;

  logic signed [XW-1:0]    xs, rs, half, ideal, diff;
  logic [WIDTH-1:0]        abs_x;
  logic [1:0]              dec_c;
  logic signed [WIDTH-1:0] err_c;
  logic [AW-1:0]           acc_sum;
  logic [WIDTH-1:0]        new_ref;

  // samp_cnt free-runs on the strobe, so a phase change only moves the pick point.
  assign capture = bus.sam_clk_en && (samp_cnt == bus.phase);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      samp_cnt <= '0;
      x_sym    <= '0;
      proc     <= 1'b0;
    end else begin
      if (bus.sam_clk_en) samp_cnt <= samp_cnt + 2'd1;
      if (capture)        x_sym    <= bus.x_in;
      proc <= capture;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    abs_x   = '0;
    dec_c   = '0;
    ideal   = '0;
    diff    = '0;
    err_c   = '0;
    xs      = {{2{x_sym[WIDTH-1]}}, x_sym};
    rs      = {2'b00, ref_level_q};
    half    = {3'b000, ref_level_q[WIDTH-1:1]};

    if (x_sym == X_MIN)      abs_x = ABS_MAX;
    else if (x_sym[WIDTH-1]) abs_x = (~x_sym) + WIDTH'(1);
    else                     abs_x = x_sym;

    if (xs < -rs) begin
      dec_c = 2'b00;
      ideal = -(rs + half);
    end else if (xs < 0) begin
      dec_c = 2'b01;
      ideal = -half;
    end else if (xs < rs) begin
      dec_c = 2'b10;
      ideal = half;
    end else begin
      dec_c = 2'b11;
      ideal = rs + half;
    end

    diff = xs - ideal;
    if (diff > ERR_MAX)      err_c = ERR_MAX[WIDTH-1:0];
    else if (diff < ERR_MIN) err_c = ERR_MIN[WIDTH-1:0];
    else                     err_c = diff[WIDTH-1:0];

    acc_sum = acc + AW'(abs_x);
    new_ref = WIDTH'(acc_sum >> ACC_LOG2);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_valid_q <= 1'b0;
      dec_q       <= '0;
      err_q       <= '0;
    end else begin
      sym_valid_q <= proc;
      if (proc) begin
        dec_q <= dec_c;
        err_q <= err_c;
      end
    end
  end

  // The completing symbol was already sliced above with the old reference.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      sym_cnt     <= '0;
      ref_level_q <= INIT_REF;
      ref_valid_q <= 1'b0;
    end else if (proc && !bus.freeze) begin
      sym_cnt <= sym_cnt + ACC_LOG2'(1);
      if (&sym_cnt) begin
        acc         <= '0;
        ref_valid_q <= 1'b1;
        if (new_ref != '0) ref_level_q <= new_ref;
      end else begin
        acc <= acc_sum;
      end
    end
  end

  assign bus.sym_valid = sym_valid_q;
  assign bus.dec       = dec_q;
  assign bus.err       = err_q;
  assign bus.ref_level = ref_level_q;
  assign bus.ref_valid = ref_valid_q;
endmodule

// File: tb/tb_sym_slicer_4ask.sv
// Randomised bench for sym_slicer_4ask: a symbol-level reference model plus
// literal expectations for the documented corner cases.
module tb_sym_slicer_4ask;
  localparam int WIDTH = 18;

  logic sys_clk;
  logic reset_n;

  sym_slicer_4ask_if #(.WIDTH(WIDTH)) bus ();

  sym_slicer_4ask #(
    .WIDTH    (WIDTH),
    .ACC_LOG2 (7),
    .INIT_REF (18'd32768)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int due;
    int dec;
    int err;
    int r;
    int rv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   cyc      = 0;
  bit   chk_en   = 0;

  // model state at capture time
  int m_samp, m_R, m_rv, m_acc, m_cnt;
  // model state as visible on the outputs
  int v_R, v_rv, last_dec, last_err;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_samp = 0; m_R = 32768; m_rv = 0; m_acc = 0; m_cnt = 0;
    v_R = 32768; v_rv = 0; last_dec = 0; last_err = 0;
  endtask

  task automatic model_capture(input int x);
    int half, ideal, d, e, a;
    exp_t ex;
    half = m_R / 2;
    if (x < -m_R)      begin d = 0; ideal = -(m_R + half); end
    else if (x < 0)    begin d = 1; ideal = -half; end
    else if (x < m_R)  begin d = 2; ideal = half; end
    else               begin d = 3; ideal = m_R + half; end
    e = x - ideal;
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
    a = (x == -131072) ? 131071 : ((x < 0) ? -x : x);
    if (!bus.freeze) begin
      m_acc += a;
      m_cnt++;
      if (m_cnt == 128) begin
        if (m_acc / 128 != 0) m_R = m_acc / 128;
        m_rv  = 1;
        m_acc = 0;
        m_cnt = 0;
      end
    end
    ex.due = cyc + 2; ex.dec = d; ex.err = e; ex.r = m_R; ex.rv = m_rv;
    q.push_back(ex);
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("sym_valid", int'(bus.sym_valid), 1);
        last_dec = e.dec; last_err = e.err; v_R = e.r; v_rv = e.rv;
        n_valid++;
      end else begin
        check("sym_valid_idle", int'(bus.sym_valid), 0);
      end
      check("dec", int'(bus.dec), last_dec);
      check("err", int'(bus.err), last_err);
      check("ref_level", int'(bus.ref_level), v_R);
      check("ref_valid", int'(bus.ref_valid), v_rv);
    end
  end

  function automatic int rand_x();
    logic signed [WIDTH-1:0] r;
    r = WIDTH'($urandom);
    if ($urandom_range(7) == 0) r = ($urandom_range(1) != 0) ? 18'sh20000 : 18'sh1FFFF;
    return int'(r);
  endfunction

  task automatic do_sample(input int x);
    @(posedge sys_clk); #1;
    bus.sam_clk_en = 1'b1;
    bus.x_in       = WIDTH'(x);
    if (m_samp == int'(bus.phase)) model_capture(x);
    m_samp = (m_samp + 1) % 4;
    @(posedge sys_clk); #1;
    bus.sam_clk_en = 1'b0;
    bus.x_in       = WIDTH'($urandom);
    @(posedge sys_clk);
    @(posedge sys_clk);
  endtask

  task automatic send_sym(input int x);
    repeat (4) do_sample((m_samp == int'(bus.phase)) ? x : rand_x());
  endtask

  task automatic check_out(input string name, input int d, input int e);
    #1;
    check({name, "_dec"}, int'(bus.dec), d);
    check({name, "_err"}, int'(bus.err), e);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #2;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    #1;
    check("rst_sym_valid", int'(bus.sym_valid), 0);
    check("rst_dec", int'(bus.dec), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_ref_level", int'(bus.ref_level), 32768);
    check("rst_ref_valid", int'(bus.ref_valid), 0);
    model_clear();
    repeat (2) @(posedge sys_clk);
    #2;
    reset_n = 1'b1;
    chk_en  = 1'b1;
  endtask

  initial begin
    int start;
    reset_n        = 1'b0;
    bus.sam_clk_en = 1'b0;
    bus.phase      = 2'd2;
    bus.freeze     = 1'b0;
    bus.x_in       = '0;
    model_clear();
    repeat (3) @(posedge sys_clk);
    #2;
    check("init_ref_level", int'(bus.ref_level), 32768);
    check("init_sym_valid", int'(bus.sym_valid), 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // phase 2 picks the 49152 out of 0,0,49152,0
    repeat (3) begin
      do_sample(0); do_sample(0); do_sample(49152); do_sample(0);
    end
    check_out("phase2", 3, 0);

    // thresholds at R = 32768
    send_sym(32767);   check_out("thr_32767", 2, 16383);
    send_sym(32768);   check_out("thr_32768", 3, -16384);
    send_sym(-1);      check_out("thr_m1", 1, 16383);
    send_sym(-32769);  check_out("thr_m32769", 0, 16383);
    send_sym(-131072); check_out("thr_min", 0, -81920);

    // phase 1 -> 3 inside one window gives two captures
    bus.phase = 2'd1;
    while (m_samp != 0) do_sample(rand_x());
    start = n_valid;
    do_sample(rand_x());
    do_sample(10000);
    bus.phase = 2'd3;
    do_sample(rand_x());
    do_sample(-50000);
    #1;
    check("phase_chg_count", n_valid - start, 2);
    check_out("phase_chg", 0, -848);
    repeat (3) send_sym(rand_x());

    // random samples with occasional phase changes
    for (int i = 0; i < 160; i++) begin
      if (i % 10 == 0) bus.phase = 2'($urandom_range(3));
      do_sample(rand_x());
    end

    // estimator convergence
    do_reset();
    bus.phase = 2'd0;
    for (int i = 0; i < 128; i++) send_sym((i % 2 == 0) ? 40000 : -40000);
    check_out("conv_last", 0, 9152);
    check("conv_ref_level", int'(bus.ref_level), 40000);
    check("conv_ref_valid", int'(bus.ref_valid), 1);

    bus.freeze = 1'b1;
    for (int i = 0; i < 128; i++) send_sym((i % 2 == 0) ? 20000 : -20000);
    check_out("freeze_last", 1, 0);
    check("freeze_ref_level", int'(bus.ref_level), 40000);
    bus.freeze = 1'b0;

    for (int i = 0; i < 128; i++) send_sym(-131072);
    check_out("sat_last", 0, -71072);
    check("sat_ref_level", int'(bus.ref_level), 131071);

    for (int i = 0; i < 128; i++) send_sym(0);
    check_out("zero_last", 2, -65535);
    check("zero_ref_level", int'(bus.ref_level), 131071);
    check("zero_ref_valid", int'(bus.ref_valid), 1);

    // mid-run reset, then first-symbol latency via the model
    do_reset();
    bus.phase = 2'd1;
    repeat (6) send_sym(rand_x());
    repeat (4) @(posedge sys_clk);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
